// File: rtl/clock_sim_pkg.sv
// Shared types and constants for the clock simulator mode controller.
package clock_sim_pkg;

    localparam int unsigned CNT_W = 28;

    typedef logic [CNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        MODE_STOP     = 2'b00,
        MODE_RUN      = 2'b01,
        MODE_SET_MIN  = 2'b10,
        MODE_SET_HOUR = 2'b11
    } mode_e;

    function automatic int unsigned sec_tc(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz - 1;
    endfunction

endpackage

// File: rtl/clock_tick_ctrl_btn_sync_edge.sv
// Button conditioner: 2-FF synchroniser, rising-edge pulse, registered level.
// AUTOREPEAT_EN adds hold-to-repeat pulses on instances built with REPEAT=1.
module btn_sync_edge
    import clock_sim_pkg::*;
#(
    parameter bit          REPEAT     = 1'b0,
    parameter int unsigned REPEAT_DLY = 50_000_000,
    parameter int unsigned REPEAT_PER = 10_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    input  logic rep_clr,
    output logic pulse
);

    // Synchroniser and edge history carry no state worth resetting.
    logic meta_q, sync_q, level_q, rise;

    always_ff @(posedge clock) begin
        meta_q  <= btn;
        sync_q  <= meta_q;
        level_q <= sync_q;
    end

    assign rise = sync_q & ~level_q;

`ifdef AUTOREPEAT_EN
    if (REPEAT) begin : g_rep
        logic   armed_q, rep_q, fire;
        count_t cnt_q;

        always_comb begin
            fire = armed_q & sync_q &
                   (cnt_q == (rep_q ? count_t'(REPEAT_PER - 1) : count_t'(REPEAT_DLY - 1)));
        end

        always_ff @(posedge clock) begin
            if (reset || rep_clr) begin
                armed_q <= 1'b0;
                rep_q   <= 1'b0;
                cnt_q   <= '0;
            end else if (rise) begin
                armed_q <= 1'b1;
                rep_q   <= 1'b0;
                cnt_q   <= '0;
            end else if (!sync_q) begin
                armed_q <= 1'b0;
                rep_q   <= 1'b0;
                cnt_q   <= '0;
            end else if (fire) begin
                rep_q   <= 1'b1;
                cnt_q   <= '0;
            end else if (armed_q) begin
                cnt_q   <= cnt_q + count_t'(1);
            end
        end

        assign pulse = rise | fire;
    end else begin : g_norep
        logic unused_in;
        localparam int unsigned unused_cfg = REPEAT_DLY + REPEAT_PER;
        assign unused_in = reset ^ rep_clr;
        assign pulse     = rise;
    end
`else
    logic unused_in;
    localparam int unsigned unused_cfg = REPEAT_DLY + REPEAT_PER + int'(REPEAT);
    assign unused_in = reset ^ rep_clr;
    assign pulse     = rise;
`endif

endmodule

// File: rtl/clock_tick_ctrl.sv
// Mode FSM, seconds prescaler and LED divider configuration for the clock simulator.
// Optional AUTOREPEAT_EN enables hold-to-repeat on the advance button.
module clock_tick_ctrl
    import clock_sim_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned TICK_HZ      = 1,
    parameter int unsigned RUN_BLINK_TC = 50_000_000,
    parameter int unsigned SET_BLINK_TC = 12_500_000,
    parameter int unsigned REPEAT_DLY   = 50_000_000,
    parameter int unsigned REPEAT_PER   = 10_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_req,
    input  logic             set_btn,
    input  logic             adv_btn,
    output logic             tick_sec,
    output logic             inc_min,
    output logic             inc_hour,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] div_count,
    output logic             div_enable
);

    localparam int unsigned SEC_TC   = sec_tc(CLK_HZ, TICK_HZ);
    localparam count_t      SEC_TC_C = count_t'(SEC_TC);

    if (SEC_TC >= (1 << CNT_W)) begin : g_sec_tc_range
        $error("SEC_TC does not fit the prescaler width");
    end

    logic   run_meta_q, run_q;
    logic   set_pulse, adv_pulse, rep_clr;
    mode_e  state_q, state_d;
    count_t presc_q, presc_d;
    logic   tick_d, pend_min_q, pend_min_d, pend_hour_q, pend_hour_d;
    count_t div_count_d;
    logic   div_enable_d;

    always_ff @(posedge clock) begin
        run_meta_q <= run_req;
        run_q      <= run_meta_q;
    end

    btn_sync_edge #(
        .REPEAT     (1'b0),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_set (
        .clock   (clock),
        .reset   (reset),
        .btn     (set_btn),
        .rep_clr (1'b0),
        .pulse   (set_pulse)
    );

    btn_sync_edge #(
        .REPEAT     (1'b1),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_adv (
        .clock   (clock),
        .reset   (reset),
        .btn     (adv_btn),
        .rep_clr (rep_clr),
        .pulse   (adv_pulse)
    );

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        tick_d       = 1'b0;
        div_count_d  = '0;
        div_enable_d = 1'b0;

        unique case (state_q)
            MODE_STOP:     if (set_pulse) state_d = MODE_SET_MIN;
                           else if (run_q) state_d = MODE_RUN;
            MODE_RUN:      if (set_pulse) state_d = MODE_SET_MIN;
                           else if (!run_q) state_d = MODE_STOP;
            MODE_SET_MIN:  if (set_pulse) state_d = MODE_SET_HOUR;
            MODE_SET_HOUR: if (set_pulse) state_d = run_q ? MODE_RUN : MODE_STOP;
        endcase

        if (state_q == MODE_RUN) begin
            if (presc_q == SEC_TC_C) begin
                presc_d = '0;
                tick_d  = (state_d == MODE_RUN);
            end else begin
                presc_d = presc_q + count_t'(1);
            end
        end
        // Resuming from STOP keeps the partial second; coming out of SET starts fresh.
        if ((state_d != state_q) &&
            ((state_d == MODE_SET_MIN) || (state_d == MODE_RUN && state_q == MODE_SET_HOUR))) begin
            presc_d = '0;
        end

        pend_min_d  = (state_q == MODE_SET_MIN)  & adv_pulse & ~set_pulse;
        pend_hour_d = (state_q == MODE_SET_HOUR) & adv_pulse & ~set_pulse;
        rep_clr     = set_pulse | (state_d != state_q);

        unique case (state_q)
            MODE_STOP: begin
                div_count_d  = '0;
                div_enable_d = 1'b0;
            end
            MODE_RUN: begin
                div_count_d  = count_t'(RUN_BLINK_TC);
                div_enable_d = 1'b1;
            end
            MODE_SET_MIN, MODE_SET_HOUR: begin
                div_count_d  = count_t'(SET_BLINK_TC);
                div_enable_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= MODE_STOP;
            presc_q     <= '0;
            tick_sec    <= 1'b0;
            pend_min_q  <= 1'b0;
            pend_hour_q <= 1'b0;
            inc_min     <= 1'b0;
            inc_hour    <= 1'b0;
            div_count   <= '0;
            div_enable  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            tick_sec    <= tick_d;
            pend_min_q  <= pend_min_d;
            pend_hour_q <= pend_hour_d;
            inc_min     <= pend_min_q;
            inc_hour    <= pend_hour_q;
            div_count   <= div_count_d;
            div_enable  <= div_enable_d;
        end
    end

    assign mode = state_q;

endmodule
